// File: rtl/timer_ctrl.sv
// mm:ss stopwatch driven by idle/start/pause/stop codes; 1-cycle registered response, no backpressure.
// Optional TIMER_LAP_EN adds lap_sec/lap_min, captured on each RUN->PAUSE transition.
module timer_ctrl #(
    parameter int CMD_SIZE      = 3,
    parameter int TICKS_PER_SEC = 50000000,
    parameter int PRESC_WIDTH   = 26
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CMD_SIZE-1:0] cmd,
    input  logic                cmd_valid,
    output logic [5:0]          sec,
    output logic [5:0]          min,
    output logic [1:0]          state,
    output logic                running,
    output logic                sec_tick,
    output logic                wrap
`ifdef TIMER_LAP_EN
    ,
    output logic [5:0]          lap_sec,
    output logic [5:0]          lap_min
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_STOP  = 2'b11;

    localparam logic [CMD_SIZE-1:0] CMD_IDLE  = CMD_SIZE'(0);
    localparam logic [CMD_SIZE-1:0] CMD_START = CMD_SIZE'(1);
    localparam logic [CMD_SIZE-1:0] CMD_PAUSE = CMD_SIZE'(2);
    localparam logic [CMD_SIZE-1:0] CMD_STOP  = CMD_SIZE'(3);

    localparam logic [PRESC_WIDTH-1:0] PRESC_MAX = PRESC_WIDTH'(TICKS_PER_SEC - 1);

    logic [PRESC_WIDTH-1:0] presc;
    logic                   cmd_ok;
    logic                   is_idle;
    logic                   is_start;
    logic                   is_pause;
    logic                   is_stop;
    logic                   clear;
    logic                   tick;
    logic                   roll;
    logic [1:0]             state_nxt;
    logic [5:0]             sec_nxt;
    logic [5:0]             min_nxt;

    assign cmd_ok   = cmd_valid && (cmd <= CMD_STOP);
    assign is_idle  = cmd_ok && (cmd == CMD_IDLE);
    assign is_start = cmd_ok && (cmd == CMD_START);
    assign is_pause = cmd_ok && (cmd == CMD_PAUSE);
    assign is_stop  = cmd_ok && (cmd == CMD_STOP);

    // An idle command beats a coincident tick: counters clear and no pulse is issued.
    assign clear = is_idle || ((state == ST_STOP) && is_start);
    assign tick  = (state == ST_RUN) && (presc == PRESC_MAX) && !is_idle;
    assign roll  = tick && (sec == 6'd59) && (min == 6'd59);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (is_start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (is_pause)     state_nxt = ST_PAUSE;
                else if (is_stop) state_nxt = ST_STOP;
                else if (is_idle) state_nxt = ST_IDLE;
            end
            default: begin
                if (is_start)     state_nxt = ST_RUN;
                else if (is_stop) state_nxt = ST_STOP;
                else if (is_idle) state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        sec_nxt = sec;
        min_nxt = min;
        if (clear) begin
            sec_nxt = 6'd0;
            min_nxt = 6'd0;
        end else if (tick) begin
            if (sec == 6'd59) begin
                sec_nxt = 6'd0;
                min_nxt = (min == 6'd59) ? 6'd0 : min + 6'd1;
            end else begin
                sec_nxt = sec + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sec      <= 6'd0;
            min      <= 6'd0;
            presc    <= '0;
            running  <= 1'b0;
            sec_tick <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state    <= state_nxt;
            running  <= (state_nxt == ST_RUN);
            sec_tick <= tick;
            wrap     <= roll;
            sec      <= sec_nxt;
            min      <= min_nxt;
            // PAUSE holds the prescaler so a resume keeps the partial second.
            if (clear) begin
                presc <= '0;
            end else if (state == ST_RUN) begin
                presc <= (presc == PRESC_MAX) ? '0 : presc + PRESC_WIDTH'(1);
            end
        end
    end

`ifdef TIMER_LAP_EN
    always_ff @(posedge clk) begin
        if (rst || is_idle) begin
            lap_sec <= 6'd0;
            lap_min <= 6'd0;
        end else if ((state == ST_RUN) && is_pause) begin
            lap_sec <= sec_nxt;
            lap_min <= min_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Randomized and directed checks of timer_ctrl against a total-seconds reference model.
module tb_timer_ctrl;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic [5:0] sec;
    logic [5:0] min;
    logic [1:0] state;
    logic       running;
    logic       sec_tick;
    logic       wrap;
`ifdef TIMER_LAP_EN
    logic [5:0] lap_sec;
    logic [5:0] lap_min;
`endif

    timer_ctrl #(.CMD_SIZE(3), .TICKS_PER_SEC(T), .PRESC_WIDTH(3)) dut (
        .clk(clk),
        .rst(rst),
        .cmd(cmd),
        .cmd_valid(cmd_valid),
        .sec(sec),
        .min(min),
        .state(state),
        .running(running),
        .sec_tick(sec_tick),
        .wrap(wrap)
`ifdef TIMER_LAP_EN
        ,
        .lap_sec(lap_sec),
        .lap_min(lap_min)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: state 0 idle, 1 run, 2 pause, 3 stop; time kept as seconds 0..3599.
    int m_st;
    int m_secs;
    int m_presc;
    bit m_tick;
    bit m_wrap;
    int m_lap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input bit r, input int c, input bit v);
        bit vc;
        vc = v && (c < 4);
        m_tick = 0;
        m_wrap = 0;
        if (r) begin
            m_st = 0; m_secs = 0; m_presc = 0; m_lap = 0;
        end else if (vc && c == 0) begin
            m_st = 0; m_secs = 0; m_presc = 0; m_lap = 0;
        end else begin
            if (m_st == 1) begin
                if (m_presc == T - 1) begin
                    m_presc = 0;
                    m_tick  = 1;
                    m_wrap  = (m_secs == 3599);
                    m_secs  = (m_secs + 1) % 3600;
                end else begin
                    m_presc++;
                end
            end
            if (vc) begin
                if (c == 1 && m_st == 3) begin
                    m_secs = 0; m_presc = 0; m_st = 1;
                end else if (c == 1) begin
                    m_st = 1;
                end else if (c == 2 && m_st == 1) begin
                    m_st = 2; m_lap = m_secs;
                end else if (c == 3 && (m_st == 1 || m_st == 2)) begin
                    m_st = 3;
                end
            end
        end
    endtask

    task automatic step(input bit r, input int c, input bit v);
        logic [16:0] exp;
        rst       = r;
        cmd       = 3'(c);
        cmd_valid = v;
        @(posedge clk);
        model(r, c, v);
        #1;
        exp = {2'(m_st), m_st == 1, m_tick, m_wrap, 6'(m_secs / 60), 6'(m_secs % 60)};
        chk("cycle", {15'd0, state, running, sec_tick, wrap, min, sec}, {15'd0, exp});
`ifdef TIMER_LAP_EN
        chk("lap", {20'd0, lap_min, lap_sec}, {20'd0, 6'(m_lap / 60), 6'(m_lap % 60)});
`endif
    endtask

    task automatic nop();
        step(0, 0, 0);
    endtask

    int  pulses;
    int  held;
    bit  found;

    initial begin
        rst = 1'b1; cmd = 3'd0; cmd_valid = 1'b0;
        m_st = 0; m_secs = 0; m_presc = 0; m_tick = 0; m_wrap = 0; m_lap = 0;

        // 1: reset then quiet
        step(1, 1, 1);
        step(1, 1, 1);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_time", {20'd0, min, sec}, 32'd0);
        chk("rst_running", {31'd0, running}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            nop();
            pulses += int'(sec_tick) + int'(wrap);
        end
        chk("quiet_pulses", pulses, 0);

        // 2: start then 12 cycles
        step(0, 1, 1);
        chk("start_running", {31'd0, running}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            nop();
            pulses += int'(sec_tick);
        end
        chk("ticks_12", pulses, 3);
        chk("sec_after_12", {26'd0, sec}, 32'd3);

        // 3: pause with prescaler at 2, resume
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (m_presc == 2) found = 1;
            else nop();
        end
        chk("presc2_found", {31'd0, found}, 32'd1);
        step(0, 2, 1);
        held = sec;
        for (int i = 0; i < 10; i++) nop();
        chk("pause_frozen", {26'd0, sec}, held);
        chk("pause_state", {30'd0, state}, 32'd2);
        step(0, 1, 1);
        chk("resume_no_tick", {31'd0, sec_tick}, 32'd0);
        nop();
        chk("resume_tick", {31'd0, sec_tick}, 32'd1);
        chk("resume_sec", {26'd0, sec}, held + 1);

        // 4: run up to 59:59 then roll
        found = 0;
        for (int i = 0; i < 16000 && !found; i++) begin
            nop();
            if (m_secs == 3599) found = 1;
        end
        chk("reach_5959", {20'd0, min, sec}, {20'd0, 6'd59, 6'd59});
        found = 0;
        for (int i = 0; i < 4 && !found; i++) begin
            nop();
            if (sec_tick) found = 1;
        end
        chk("roll_seen", {31'd0, found}, 32'd1);
        chk("roll_wrap", {31'd0, wrap}, 32'd1);
        chk("roll_time", {20'd0, min, sec}, 32'd0);
        nop();
        chk("wrap_1cyc", {31'd0, wrap}, 32'd0);

        // 5: stop at 00:07, restart, idle on tick cycle
        step(0, 0, 1);
        step(0, 1, 1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            nop();
            if (m_secs == 7) found = 1;
        end
        step(0, 3, 1);
        for (int i = 0; i < 8; i++) nop();
        chk("stop_state", {30'd0, state}, 32'd3);
        chk("stop_hold", {20'd0, min, sec}, 32'd7);
        step(0, 1, 1);
        chk("restart_state", {30'd0, state}, 32'd1);
        chk("restart_clear", {20'd0, min, sec}, 32'd0);
        for (int i = 0; i < 6; i++) nop();
        found = 0;
        for (int i = 0; i < 4 && !found; i++) begin
            if (m_presc == T - 1) found = 1;
            else nop();
        end
        chk("tickcyc_found", {31'd0, found}, 32'd1);
        step(0, 0, 1);
        chk("idle_state", {30'd0, state}, 32'd0);
        chk("idle_no_tick", {31'd0, sec_tick}, 32'd0);
        chk("idle_clear", {20'd0, min, sec}, 32'd0);

        // 6: ignored commands
        step(0, 1, 1);
        step(0, 7, 1);
        chk("bad_code", {30'd0, state}, 32'd1);
        step(0, 2, 1);
        step(0, 1, 0);
        chk("no_valid", {30'd0, state}, 32'd2);
`ifdef TIMER_LAP_EN
        step(0, 0, 1);
        step(0, 1, 1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            nop();
            if (m_secs == 2) found = 1;
        end
        step(0, 2, 1);
        chk("lap_sec2", {26'd0, lap_sec}, 32'd2);
`endif

        // random commands, occasional reset
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 149) == 0, int'($urandom_range(0, 7)),
                 $urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
